// File: rtl/uart_rx_cfg_if.sv
// Serial-line side and decoded-frame side of the configurable UART receiver.
// master = receiver, slave = line driver / frame consumer.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] data_o;
  logic                 valid_o;
  logic                 parity_err_o;
  logic                 frame_err_o;
  logic                 break_o;
  logic                 busy_o;

  modport master (
    input  rx,
    output data_o, valid_o, parity_err_o,
    output frame_err_o, break_o, busy_o
  );

  modport slave (
    output rx,
    input  data_o, valid_o, parity_err_o,
    input  frame_err_o, break_o, busy_o
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: N data bits, optional parity, 1/2 stop bits,
// start glitch rejection, error/break flags and post-error idle wait.
module uart_rx_cfg #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,
  parameter int STOP_BITS       = 1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.master bus
);
  localparam int CW = $clog2(CLOCKS_PER_BAUD);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BAUD / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  localparam logic ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 pbit_q, pbit_d;
  logic                 ferr_q, ferr_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 fe_q, fe_d;
  logic                 brk_q, brk_d;
  logic                 valid_q, valid_d;
  logic                 rxs, tick, ferr_n, last_stop;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign tick      = (cnt_q == '0);
  assign ferr_n    = ferr_q | ~rxs;
  assign last_stop = (STOP_BITS == 1) || stop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sync_q  <= '1;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      pbit_q  <= 1'b0;
      ferr_q  <= 1'b0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      fe_q    <= 1'b0;
      brk_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.rx};
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      pbit_q  <= pbit_d;
      ferr_q  <= ferr_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      fe_q    <= fe_d;
      brk_q   <= brk_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    pbit_d  = pbit_q;
    ferr_d  = ferr_q;
    stop_d  = stop_q;
    data_d  = data_q;
    perr_d  = perr_q;
    fe_d    = fe_q;
    brk_d   = brk_q;
    valid_d = 1'b0;
    if (state_q != S_IDLE && state_q != S_WAIT && !tick)
      cnt_d = cnt_q - 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF;
        end
      end
      S_START: begin
        if (tick) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL;
            bidx_d  = '0;
            ferr_d  = 1'b0;
            stop_d  = 1'b0;
            pbit_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          sh_d   = {rxs, sh_q[DATA_BITS-1:1]};
          cnt_d  = FULL;
          bidx_d = bidx_q + 1'b1;
          if (bidx_q == LAST)
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (tick) begin
          pbit_d  = rxs;
          cnt_d   = FULL;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          ferr_d = ferr_n;
          if (last_stop) begin
            // Counter stays 0 so a back-to-back start is caught in IDLE.
            state_d = rxs ? S_IDLE : S_WAIT;
            data_d  = sh_q;
            perr_d  = (PARITY != 0) && ((^sh_q ^ pbit_q) != ODD);
            fe_d    = ferr_n;
            brk_d   = (sh_q == '0) && !pbit_q && ferr_n;
            valid_d = 1'b1;
          end else begin
            stop_d = 1'b1;
            cnt_d  = FULL;
          end
        end
      end
      S_WAIT: begin
        if (rxs)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign bus.parity_err_o = perr_q;
  assign bus.frame_err_o  = fe_q;
  assign bus.break_o      = brk_q;
  assign bus.busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: four receiver configurations at 16 clk/bit
// driven with hand-built frames.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   vcnt0 = 0, vcnt1 = 0, vcnt2 = 0, vcnt3 = 0;
  time  t_fall = 0, t_valid0 = 0;

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DATA_BITS(8)) bus0 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) bus2 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) bus3 ();

  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .PARITY(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));
  uart_rx_cfg #(.CLOCKS_PER_BAUD(CPB), .DATA_BITS(7)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));

  always @(negedge clk) begin
    if (bus0.valid_o) begin
      vcnt0    <= vcnt0 + 1;
      t_valid0 <= $time;
    end
    if (bus1.valid_o) vcnt1 <= vcnt1 + 1;
    if (bus2.valid_o) vcnt2 <= vcnt2 + 1;
    if (bus3.valid_o) vcnt3 <= vcnt3 + 1;
  end

  task automatic set_rx(input int w, input logic v);
    case (w)
      0: bus0.rx = v;
      1: bus1.rx = v;
      2: bus2.rx = v;
      default: bus3.rx = v;
    endcase
  endtask

  task automatic send_bits(input int w, input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      set_rx(w, v[i]);
      if (i == 0) t_fall = $time;
      repeat (CPB - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int w = 0; w < 4; w++) set_rx(w, 1'b1);
    idle(3);
    tests++;
    if (bus0.data_o !== 8'h00) begin
      fails++;
      $display("FAIL reset_data got %h want 00", bus0.data_o);
    end
    tests++;
    if ({bus0.valid_o, bus0.parity_err_o, bus0.frame_err_o,
         bus0.break_o, bus0.busy_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 00000",
        {bus0.valid_o, bus0.parity_err_o, bus0.frame_err_o,
         bus0.break_o, bus0.busy_o});
    end
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_basic;
    int c0;
    logic busy_mid;
    c0 = vcnt0;
    fork
      send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
      begin
        idle(40);
        busy_mid = bus0.busy_o;
      end
    join
    idle(CPB);
    tests++;
    if (busy_mid !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_mid got %b want 1", busy_mid);
    end
    tests++;
    if (vcnt0 - c0 !== 1) begin
      fails++;
      $display("FAIL basic_count got %0d want 1", vcnt0 - c0);
    end
    tests++;
    if (bus0.data_o !== 8'hA5) begin
      fails++;
      $display("FAIL basic_data got %h want a5", bus0.data_o);
    end
    tests++;
    if ({bus0.parity_err_o, bus0.frame_err_o, bus0.break_o,
         bus0.busy_o} !== 4'b0) begin
      fails++;
      $display("FAIL basic_flags got %b want 0000",
        {bus0.parity_err_o, bus0.frame_err_o, bus0.break_o, bus0.busy_o});
    end
    tests++;
    if (t_valid0 - t_fall !== 64'd1550) begin
      fails++;
      $display("FAIL basic_latency got %0t want 1550", t_valid0 - t_fall);
    end
  endtask

  task automatic test_glitch;
    int c0;
    c0 = vcnt0;
    @(negedge clk);
    set_rx(0, 1'b0);
    idle(6);
    set_rx(0, 1'b1);
    idle(2 * CPB);
    tests++;
    if (vcnt0 != c0 || bus0.data_o !== 8'hA5 || bus0.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL glitch got cnt=%0d data=%h busy=%b want 0 a5 0",
        vcnt0 - c0, bus0.data_o, bus0.busy_o);
    end
  endtask

  task automatic test_parity;
    int c1;
    c1 = vcnt1;
    send_bits(1, 16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
    idle(CPB);
    tests++;
    if (vcnt1 - c1 !== 1 || bus1.data_o !== 8'h03 ||
        bus1.parity_err_o !== 1'b1 || bus1.frame_err_o !== 1'b0) begin
      fails++;
      $display("FAIL parity_bad got cnt=%0d data=%h pe=%b fe=%b want 1 03 1 0",
        vcnt1 - c1, bus1.data_o, bus1.parity_err_o, bus1.frame_err_o);
    end
    send_bits(1, 16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
    idle(CPB);
    tests++;
    if (vcnt1 - c1 !== 2 || bus1.data_o !== 8'h03 ||
        bus1.parity_err_o !== 1'b0) begin
      fails++;
      $display("FAIL parity_good got cnt=%0d data=%h pe=%b want 2 03 0",
        vcnt1 - c1, bus1.data_o, bus1.parity_err_o);
    end
  endtask

  task automatic test_stop2;
    int c2;
    c2 = vcnt2;
    send_bits(2, 16'({1'b0, 1'b1, 8'h5A, 1'b0}), 11);
    idle(2 * CPB);
    tests++;
    if (vcnt2 - c2 !== 1 || bus2.data_o !== 8'h5A ||
        bus2.frame_err_o !== 1'b1 || bus2.break_o !== 1'b0) begin
      fails++;
      $display("FAIL stop2_err got cnt=%0d data=%h fe=%b brk=%b want 1 5a 1 0",
        vcnt2 - c2, bus2.data_o, bus2.frame_err_o, bus2.break_o);
    end
    tests++;
    if (bus2.busy_o !== 1'b1) begin
      fails++;
      $display("FAIL stop2_wait got busy=%b want 1", bus2.busy_o);
    end
    set_rx(2, 1'b1);
    idle(CPB);
    tests++;
    if (bus2.busy_o !== 1'b0) begin
      fails++;
      $display("FAIL stop2_idle got busy=%b want 0", bus2.busy_o);
    end
    send_bits(2, 16'({2'b11, 8'h3C, 1'b0}), 11);
    idle(CPB);
    tests++;
    if (vcnt2 - c2 !== 2 || bus2.data_o !== 8'h3C ||
        bus2.frame_err_o !== 1'b0 || bus2.break_o !== 1'b0) begin
      fails++;
      $display("FAIL stop2_clean got cnt=%0d data=%h fe=%b brk=%b want 2 3c 0 0",
        vcnt2 - c2, bus2.data_o, bus2.frame_err_o, bus2.break_o);
    end
  endtask

  task automatic test_break;
    int c0;
    c0 = vcnt0;
    @(negedge clk);
    set_rx(0, 1'b0);
    idle(20 * CPB);
    tests++;
    if (bus0.busy_o !== 1'b1) begin
      fails++;
      $display("FAIL break_hold got busy=%b want 1", bus0.busy_o);
    end
    set_rx(0, 1'b1);
    idle(3 * CPB);
    tests++;
    if (vcnt0 - c0 !== 1 || bus0.data_o !== 8'h00) begin
      fails++;
      $display("FAIL break_count got cnt=%0d data=%h want 1 00",
        vcnt0 - c0, bus0.data_o);
    end
    tests++;
    if ({bus0.break_o, bus0.frame_err_o, bus0.parity_err_o,
         bus0.busy_o} !== 4'b1100) begin
      fails++;
      $display("FAIL break_flags got %b want 1100",
        {bus0.break_o, bus0.frame_err_o, bus0.parity_err_o, bus0.busy_o});
    end
  endtask

  task automatic test_reset_mid;
    int c0;
    c0 = vcnt0;
    send_bits(0, 16'h0000, 4);
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    tests++;
    if ({bus0.data_o, bus0.valid_o, bus0.break_o, bus0.frame_err_o,
         bus0.busy_o} !== 12'h000) begin
      fails++;
      $display("FAIL rstmid_out got data=%h v=%b brk=%b fe=%b busy=%b want 0",
        bus0.data_o, bus0.valid_o, bus0.break_o, bus0.frame_err_o,
        bus0.busy_o);
    end
    set_rx(0, 1'b1);
    idle(2);
    rst = 1'b0;
    idle(12 * CPB);
    tests++;
    if (vcnt0 != c0) begin
      fails++;
      $display("FAIL rstmid_abort got cnt=%0d want 0", vcnt0 - c0);
    end
    send_bits(0, 16'({1'b1, 8'h81, 1'b0}), 10);
    idle(CPB);
    tests++;
    if (vcnt0 - c0 !== 1 || bus0.data_o !== 8'h81 ||
        {bus0.parity_err_o, bus0.frame_err_o, bus0.break_o} !== 3'b0) begin
      fails++;
      $display("FAIL rstmid_next got cnt=%0d data=%h want 1 81 flags 0",
        vcnt0 - c0, bus0.data_o);
    end
  endtask

  task automatic test_bits7;
    int c3;
    c3 = vcnt3;
    send_bits(3, 16'({1'b1, 7'h7F, 1'b0}), 9);
    idle(CPB);
    tests++;
    if (vcnt3 - c3 !== 1 || bus3.data_o !== 7'h7F ||
        bus3.frame_err_o !== 1'b0) begin
      fails++;
      $display("FAIL bits7_7f got cnt=%0d data=%h fe=%b want 1 7f 0",
        vcnt3 - c3, bus3.data_o, bus3.frame_err_o);
    end
    send_bits(3, 16'({1'b1, 7'h2A, 1'b0}), 9);
    idle(CPB);
    tests++;
    if (vcnt3 - c3 !== 2 || bus3.data_o !== 7'h2A) begin
      fails++;
      $display("FAIL bits7_2a got cnt=%0d data=%h want 2 2a",
        vcnt3 - c3, bus3.data_o);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_glitch;
    test_parity;
    test_stop2;
    test_break;
    test_reset_mid;
    test_bits7;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
